// File: rtl/adjustable_frequency_divider_pkg.sv
// adjustable_frequency_divider_pkg: default sizing and divisor limits for the divider
package adjustable_frequency_divider_pkg;
  localparam int CNT_W_DEF    = 8;
  localparam int DIV_MIN_DEF  = 1;
  localparam int DIV_MAX_DEF  = 16;
  localparam int DIV_STEP_DEF = 1;
  localparam int DIV_INIT_DEF = 1;
endpackage

// File: rtl/adjustable_frequency_divider_if.sv
// adjustable_frequency_divider_if: step request in, divided clock out
interface adjustable_frequency_divider_if;
  logic step_divisor;
  logic clock_out;
  modport master (output step_divisor, input clock_out);
  modport slave (input step_divisor, output clock_out);
endinterface

// File: rtl/adjustable_frequency_divider_step_edge_detect.sv
// step_edge_detect: optional 2-flop synchronizer (ADJUSTABLE_FREQUENCY_DIVIDER_SYNC_EN) plus rising-edge pulse
module step_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic level_in,
  output logic pulse_out
);
  logic lvl;
  logic step_q, step_d;
`ifdef ADJUSTABLE_FREQUENCY_DIVIDER_SYNC_EN
  logic [1:0] sync_q, sync_d;
  // shift the raw level through two flops before it is trusted
  always_comb begin
    sync_d = {sync_q[0], level_in};
    lvl = sync_q[1];
  end
  // synchronizer flops
  always_ff @(posedge clock_in) sync_q <= reset ? 2'b00 : sync_d;
`else
  assign lvl = level_in;
`endif
  // remember last sampled level so a held-high input yields one pulse
  always_comb step_d = lvl;
  // previous-level flop
  always_ff @(posedge clock_in) step_q <= reset ? 1'b0 : step_d;
  assign pulse_out = lvl & ~step_q;
endmodule

// File: rtl/adjustable_frequency_divider.sv
// adjustable_frequency_divider: 50% duty divider with stepped, wrapping half-period (ADJUSTABLE_FREQUENCY_DIVIDER_SYNC_EN adds step synchronizer)
module adjustable_frequency_divider
  import adjustable_frequency_divider_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_MIN  = DIV_MIN_DEF,
  parameter int DIV_MAX  = DIV_MAX_DEF,
  parameter int DIV_STEP = DIV_STEP_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input logic clock_in,
  input logic reset,
  adjustable_frequency_divider_if.slave bus
);
  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W:0]   MAX_X  = CW1'(DIV_MAX);
  localparam logic [CNT_W:0]   STEP_X = CW1'(DIV_STEP);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(DIV_INIT);
  logic step;
  logic wrap;
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] div_next_q, div_next_d, div_act_q, div_act_d, cnt_q, cnt_d;
  logic clock_out_q, clock_out_d;
  step_edge_detect u_step (
    .clock_in (clock_in),
    .reset    (reset),
    .level_in (bus.step_divisor),
    .pulse_out(step)
  );
  // advance requested divisor on a step; at each half-period boundary toggle and adopt it
  always_comb begin
    sum = {1'b0, div_next_q} + STEP_X;
    div_next_d = step ? (sum > MAX_X ? MIN_V : sum[CNT_W-1:0]) : div_next_q;
    wrap = cnt_q == div_act_q - 1'b1;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    clock_out_d = wrap ? ~clock_out_q : clock_out_q;
    div_act_d = wrap ? div_next_q : div_act_q;
  end
  // state registers
  always_ff @(posedge clock_in) begin
    if (reset) begin
      div_next_q <= INIT_V;
      div_act_q <= INIT_V;
      cnt_q <= '0;
      clock_out_q <= 1'b0;
    end else begin
      div_next_q <= div_next_d;
      div_act_q <= div_act_d;
      cnt_q <= cnt_d;
      clock_out_q <= clock_out_d;
    end
  end
  assign bus.clock_out = clock_out_q;
endmodule

// File: tb/tb_adjustable_frequency_divider.sv
// tb_adjustable_frequency_divider: random + directed check of divider against a countdown model
module tb_adjustable_frequency_divider;
  import adjustable_frequency_divider_pkg::*;
  logic clock_in = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic m_out, m_prev, m_s1, m_s2;
  int m_rem, m_half, m_req;
  adjustable_frequency_divider_if bus ();
  adjustable_frequency_divider dut (
    .clock_in(clock_in),
    .reset   (reset),
    .bus     (bus)
  );
  always #10 clock_in = ~clock_in;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  // model: output toggles when the remaining count of the current half runs out
  task automatic model_step(input logic s, input logic r);
    logic eff, edge_seen;
    if (r) begin
      m_out = 1'b0; m_half = DIV_INIT_DEF; m_req = DIV_INIT_DEF; m_rem = DIV_INIT_DEF;
      m_prev = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
`ifdef ADJUSTABLE_FREQUENCY_DIVIDER_SYNC_EN
      eff = m_s2; m_s2 = m_s1; m_s1 = s;
`else
      eff = s;
`endif
      edge_seen = eff && !m_prev;
      m_prev = eff;
      m_rem--;
      if (m_rem == 0) begin
        m_out = ~m_out; m_half = m_req; m_rem = m_half;
      end
      if (edge_seen) m_req = (m_req + DIV_STEP_DEF > DIV_MAX_DEF) ? DIV_MIN_DEF : m_req + DIV_STEP_DEF;
    end
  endtask
  task automatic cyc(input logic s, input logic r);
    bus.step_divisor = s;
    reset = r;
    @(posedge clock_in);
    model_step(s, r);
    @(negedge clock_in);
    chk("clock_out", bus.clock_out, m_out);
  endtask
  task automatic pulse();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask
  task automatic measure(output int len);
    logic v;
    int n;
    n = 0; v = bus.clock_out;
    while (bus.clock_out === v && n < 100) begin cyc(1'b0, 1'b0); n++; end
    n = 0; v = bus.clock_out;
    while (bus.clock_out === v && n < 100) begin cyc(1'b0, 1'b0); n++; end
    len = n;
  endtask
  initial begin
    int len;
    logic s;
    bus.step_divisor = 1'b0;
    @(negedge clock_in);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("reset_out", bus.clock_out, 0);
    cyc(1'b0, 1'b0);
    chk("first_rise", bus.clock_out, 1);
    cyc(1'b0, 1'b0);
    chk("first_fall", bus.clock_out, 0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("held_req", m_req, 2);
    measure(len);
    chk("half_after_step", len, 2);
    for (int i = 0; i < 14; i++) pulse();
    chk("req_16", m_req, 16);
    measure(len);
    chk("half_16", len, 16);
    pulse();
    chk("req_wrap", m_req, 1);
    measure(len);
    chk("half_wrap", len, 1);
    for (int i = 0; i < 7; i++) pulse();
    measure(len);
    chk("half_8", len, 8);
    for (int i = 0; i < 3; i++) pulse();
    chk("req_acc", m_req, 11);
    measure(len);
    chk("half_acc", len, 11);
    for (int i = 0; i < 40 && bus.clock_out !== 1'b1; i++) cyc(1'b0, 1'b0);
    chk("high_before_reset", bus.clock_out, 1);
    cyc(1'b1, 1'b1);
    chk("mid_reset_out", bus.clock_out, 0);
    cyc(1'b0, 1'b0);
    chk("post_reset_rise", bus.clock_out, 1);
    cyc(1'b0, 1'b0);
    chk("post_reset_fall", bus.clock_out, 0);
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      cyc(s, $urandom_range(0, 299) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
